// File: rtl/alu_seq32.sv
// Sequencing front-end for an external 16-bit combinational ALU: runs one pass
// for 16-bit commands, two chained passes for 32-bit commands, and returns a registered result.
module alu_seq32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic        cmd_wide,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic        cmd_ci,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [1:0]  alu_opcode,
  output logic        alu_ci,
  input  logic [15:0] alu_out,
  input  logic        alu_carryout,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_carry,
  output logic        res_zero,
  output logic        res_neg,
  output logic        res_ovf
);

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_TWOS = 2'b10;
  localparam logic [1:0] OP_XOR  = 2'b11;

  typedef enum logic [1:0] {IDLE = 2'd0, LO = 2'd1, HI = 2'd2, DONE = 2'd3} state_t;

  state_t      state_r, state_nxt_s;
  logic [1:0]  op_r;
  logic        wide_r;
  logic [31:0] a_r, b_r;
  logic [15:0] alu_a_r, alu_b_r, alu_a_nxt_s, alu_b_nxt_s;
  logic [1:0]  alu_op_r, alu_op_nxt_s;
  logic        alu_ci_r, alu_ci_nxt_s;
  logic [31:0] res_data_r, result_s;
  logic [3:0]  flags_r, flags_s;
  logic        pass_carry_s, finish_s, accept_s;

  // Flags {carry, zero, neg, ovf} evaluated on the active width of the command.
  function automatic logic [3:0] calc_flags(input logic [1:0] op, input logic wide,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] r, input logic carry);
    logic a_msb, b_msb, r_msb, ovf;
    a_msb = wide ? a[31] : a[15];
    b_msb = wide ? b[31] : b[15];
    r_msb = wide ? r[31] : r[15];
    case (op)
      OP_ADD:  ovf = (a_msb == b_msb) && (r_msb != a_msb);
      OP_SUB:  ovf = (a_msb != b_msb) && (r_msb != a_msb);
      OP_TWOS: ovf = b_msb && r_msb;
      default: ovf = 1'b0;
    endcase
    return {carry, (r == 32'h0000_0000), r_msb, ovf};
  endfunction

  assign cmd_ready  = (state_r == IDLE) && !rst;
  assign accept_s   = cmd_valid && cmd_ready;
  assign res_valid  = (state_r == DONE);
  assign alu_a      = alu_a_r;
  assign alu_b      = alu_b_r;
  assign alu_opcode = alu_op_r;
  assign alu_ci     = alu_ci_r;
  assign res_data   = res_data_r;
  assign {res_carry, res_zero, res_neg, res_ovf} = flags_r;

  // Next state, next ALU drive, and the result/flags of the pass in progress.
  always_comb begin
    state_nxt_s  = state_r;
    alu_a_nxt_s  = 16'h0000;
    alu_b_nxt_s  = 16'h0000;
    alu_op_nxt_s = 2'b00;
    alu_ci_nxt_s = 1'b0;
    finish_s     = 1'b0;
    // XOR leaves the ALU carry undefined, so it never reaches a register.
    if (op_r == OP_XOR) begin
      pass_carry_s = 1'b0;
    end else begin
      pass_carry_s = alu_carryout;
    end
    if (state_r == HI) begin
      result_s = {alu_out, res_data_r[15:0]};
    end else begin
      result_s = {16'h0000, alu_out};
    end
    flags_s = calc_flags(op_r, wide_r, a_r, b_r, result_s, pass_carry_s);
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s  = LO;
          alu_a_nxt_s  = cmd_a[15:0];
          alu_b_nxt_s  = cmd_b[15:0];
          alu_op_nxt_s = cmd_op;
          alu_ci_nxt_s = (cmd_op == OP_ADD) ? cmd_ci : 1'b0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LO: begin
        if (wide_r) begin
          // Upper half always runs as an add chained on the low carry, except XOR.
          state_nxt_s  = HI;
          alu_op_nxt_s = (op_r == OP_XOR) ? OP_XOR : OP_ADD;
          alu_ci_nxt_s = pass_carry_s;
          case (op_r)
            OP_ADD:  begin alu_a_nxt_s = a_r[31:16]; alu_b_nxt_s = b_r[31:16];  end
            OP_SUB:  begin alu_a_nxt_s = a_r[31:16]; alu_b_nxt_s = ~b_r[31:16]; end
            OP_TWOS: begin alu_a_nxt_s = 16'h0000;   alu_b_nxt_s = ~b_r[31:16]; end
            default: begin alu_a_nxt_s = a_r[31:16]; alu_b_nxt_s = b_r[31:16];  end
          endcase
        end else begin
          state_nxt_s = DONE;
          finish_s    = 1'b1;
        end
      end
      HI: begin
        state_nxt_s = DONE;
        finish_s    = 1'b1;
      end
      DONE: begin
        if (res_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, command capture, ALU drive and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      op_r       <= 2'b00;
      wide_r     <= 1'b0;
      a_r        <= 32'h0000_0000;
      b_r        <= 32'h0000_0000;
      alu_a_r    <= 16'h0000;
      alu_b_r    <= 16'h0000;
      alu_op_r   <= 2'b00;
      alu_ci_r   <= 1'b0;
      res_data_r <= 32'h0000_0000;
      flags_r    <= 4'h0;
    end else begin
      state_r  <= state_nxt_s;
      alu_a_r  <= alu_a_nxt_s;
      alu_b_r  <= alu_b_nxt_s;
      alu_op_r <= alu_op_nxt_s;
      alu_ci_r <= alu_ci_nxt_s;
      if (accept_s) begin
        op_r   <= cmd_op;
        wide_r <= cmd_wide;
        a_r    <= cmd_a;
        b_r    <= cmd_b;
      end
      if ((state_r == LO) || (state_r == HI)) begin
        res_data_r <= result_s;
      end
      if (finish_s) begin
        flags_r <= flags_s;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq32.sv
// Self-checking bench for alu_seq32: a stand-in 16-bit ALU plus a full-width
// arithmetic reference model, directed test-plan steps and random commands.
module tb_alu_seq32;

  logic        clk = 1'b0;
  logic        rst, cmd_valid, cmd_ready, cmd_wide, cmd_ci;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_a, cmd_b;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [1:0]  alu_opcode;
  logic        alu_ci, alu_carryout;
  logic        res_valid, res_ready, res_carry, res_zero, res_neg, res_ovf;
  logic [31:0] res_data;
  logic        xor_co;
  logic [16:0] alu_sum;
  int          chk_cnt = 0;
  int          pass_cnt = 0;
  logic        hi_ci;

  always #5 clk = ~clk;

  alu_seq32 dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_wide(cmd_wide), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_ci(cmd_ci),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_ci(alu_ci),
    .alu_out(alu_out), .alu_carryout(alu_carryout),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_carry(res_carry), .res_zero(res_zero), .res_neg(res_neg), .res_ovf(res_ovf)
  );

  // Stand-in combinational ALU; its XOR carry is whatever the bench chooses.
  always_comb begin
    alu_sum = 17'h00000;
    case (alu_opcode)
      2'b00:   alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {16'h0000, alu_ci};
      2'b01:   alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1;
      2'b10:   alu_sum = {1'b0, ~alu_b} + 17'd1;
      default: alu_sum = {xor_co, alu_a ^ alu_b};
    endcase
  end
  assign alu_out      = alu_sum[15:0];
  assign alu_carryout = alu_sum[16];

  // Reference: {carry, zero, neg, ovf, result} from plain N-bit arithmetic.
  function automatic logic [35:0] model(input logic [1:0] op, input logic wide,
                                        input logic [31:0] a, input logic [31:0] b, input logic ci);
    logic [31:0] mask, am, bm, r;
    logic [32:0] full;
    logic        carry, neg, ovf;
    int          n;
    n    = wide ? 32 : 16;
    mask = wide ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    am   = a & mask;
    bm   = b & mask;
    case (op)
      2'b00:   full = {1'b0, am} + {1'b0, bm} + {32'h0, ci};
      2'b01:   full = {1'b0, am} + {1'b0, ~bm & mask} + 33'd1;
      2'b10:   full = {1'b0, ~bm & mask} + 33'd1;
      default: full = {1'b0, am ^ bm};
    endcase
    r     = full[31:0] & mask;
    carry = (op == 2'b11) ? 1'b0 : full[n];
    neg   = r[n-1];
    case (op)
      2'b00:   ovf = (am[n-1] == bm[n-1]) && (neg != am[n-1]);
      2'b01:   ovf = (am[n-1] != bm[n-1]) && (neg != am[n-1]);
      2'b10:   ovf = bm[n-1] && neg;
      default: ovf = 1'b0;
    endcase
    return {carry, (r == 32'h0), neg, ovf, r};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt = chk_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One full command: handshake, latency, result, optional backpressure, release.
  task automatic run_cmd(input logic [1:0] op, input logic wide, input logic [31:0] a,
                         input logic [31:0] b, input logic ci, input int hold, output logic hci);
    logic [35:0] e;
    int n;
    e = model(op, wide, a, b, ci);
    hci = 1'b0;
    @(negedge clk);
    chk("ready_idle", {31'h0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_wide = wide; cmd_a = a; cmd_b = b; cmd_ci = ci;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("ready_busy", {31'h0, cmd_ready}, 32'd0);
    n = 0;
    while (res_valid !== 1'b1 && n < 8) begin
      @(negedge clk);
      n = n + 1;
      if (n == 1 && wide) hci = alu_ci;
    end
    chk("latency", n, wide ? 32'd2 : 32'd1);
    chk("data", res_data, e[31:0]);
    chk("flags", {28'h0, res_carry, res_zero, res_neg, res_ovf}, {28'h0, e[35:32]});
    chk("alu_done", {alu_a, alu_b} | {29'h0, alu_opcode, alu_ci}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      cmd_valid = 1'b1;
      chk("hold_data", res_data, e[31:0]);
      chk("hold_ctl", {29'h0, res_valid, cmd_ready, res_carry}, {29'h0, 1'b1, 1'b0, e[35]});
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("released", {30'h0, res_valid, cmd_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_wide = 1'b0;
    cmd_a = 32'h0; cmd_b = 32'h0; cmd_ci = 1'b0; res_ready = 1'b0; xor_co = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out", {res_data[31:4], res_carry, res_zero, res_neg, res_ovf} | res_data, 32'd0);
    chk("rst_ctl", {30'h0, res_valid, cmd_ready}, 32'd0);
    chk("rst_alu", {alu_a, alu_b} | {29'h0, alu_opcode, alu_ci}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_ready", {31'h0, cmd_ready}, 32'd1);

    run_cmd(2'b00, 1'b0, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 0, hi_ci);
    run_cmd(2'b00, 1'b1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 0, hi_ci);
    chk("hi_ci_add", {31'h0, hi_ci}, 32'd1);
    run_cmd(2'b01, 1'b1, 32'h0001_0000, 32'h0000_0001, 1'b0, 0, hi_ci);
    run_cmd(2'b01, 1'b1, 32'h0000_0000, 32'h0000_0001, 1'b0, 0, hi_ci);
    run_cmd(2'b01, 1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 0, hi_ci);
    run_cmd(2'b10, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 0, hi_ci);
    run_cmd(2'b10, 1'b1, 32'h0000_0000, 32'h8000_0000, 1'b0, 0, hi_ci);
    run_cmd(2'b10, 1'b1, 32'h0000_0000, 32'h0000_0001, 1'b0, 0, hi_ci);
    xor_co = 1'b1;
    run_cmd(2'b11, 1'b0, 32'h0000_AAAA, 32'h0000_AAAA, 1'b1, 0, hi_ci);
    xor_co = 1'bx;
    run_cmd(2'b11, 1'b0, 32'h0000_AAAA, 32'h0000_AAAA, 1'b0, 0, hi_ci);
    xor_co = 1'b1;
    run_cmd(2'b11, 1'b1, 32'hFFFF_0000, 32'h0F0F_0000, 1'b0, 0, hi_ci);
    run_cmd(2'b00, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 10, hi_ci);

    // Reset while the upper half of a wide command is in flight.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_wide = 1'b1; cmd_a = 32'h1234_5678; cmd_b = 32'h0000_0001;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ctl", {30'h0, res_valid, cmd_ready}, 32'd0);
    chk("mid_rst_alu", {alu_a, alu_b} | {29'h0, alu_opcode, alu_ci}, 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", {31'h0, cmd_ready}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_result", {31'h0, res_valid}, 32'd0);
    end

    for (int k = 0; k < 40; k++) begin
      xor_co = 1'($urandom_range(0, 1));
      run_cmd(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, $urandom,
              1'($urandom_range(0, 1)), 0, hi_ci);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/alu_seq32.md
# alu_seq32

Sequencing front-end for the 16-bit ALU. It accepts 32-bit or 16-bit commands over a valid/ready handshake and drives the combinational ALU's operand, opcode and carry-in ports. It captures the ALU result and carry-out, chaining two passes for 32-bit operations. It returns a registered result with status flags over a second valid/ready handshake.

## Interface
- No parameters. Widths are fixed: ALU 16 bits, command 32 bits.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_op`  in  2  ALU opcode:
  - 00 = add a+b+ci
  - 01 = sub a−b
  - 10 = two's complement of b
  - 11 = xor
- `cmd_wide`  in  1  1 = 32-bit operation, 0 = 16-bit (uses [15:0] only).
- `cmd_a`, `cmd_b`  in  32  operands.
- `cmd_ci`  in  1  carry-in. Used by op 00 only.
- `alu_a`, `alu_b`  out  16  ALU operands.
- `alu_opcode`  out  2  ALU opcode.
- `alu_ci`  out  1  ALU carry-in.
- `alu_out`  in  16  ALU result. Combinational from `alu_*` in the same cycle.
- `alu_carryout`  in  1  ALU carry-out. May be X for opcode 11.
- `res_valid`  out  1  result present.
- `res_ready`  in  1  consumer accepts result.
- `res_data`  out  32  result. For 16-bit ops, [31:16] = 0.
- `res_carry`, `res_zero`, `res_neg`, `res_ovf`  out  1 each  status flags.

## Operation
FSM states: IDLE, LO, HI, DONE.

- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`&`cmd_ready`: register op, wide, a, b, ci; go to LO.
- **LO** (low half)
  - `alu_a`=a[15:0], `alu_b`=b[15:0].
  - Narrow op: `alu_opcode`=op; `alu_ci`=ci for op 00, else 0.
  - Wide op, by opcode:
    - add: opcode 00, ci=ci.
    - sub: opcode 01.
    - twos: opcode 10.
    - xor: opcode 11.
  - At the end of the cycle, capture `alu_out` into result[15:0] and the carry into a carry register.
  - Narrow → DONE; wide → HI.
- **HI** (high half; `alu_ci`=captured low carry)
  - add: opcode 00, a[31:16], b[31:16].
  - sub: opcode 00, a[31:16], ~b[31:16]. The ALU sub path hard-wires ci=1, so it is not used here.
  - twos: opcode 00, alu_a=0, ~b[31:16].
  - xor: opcode 11, ci=0.
  - Capture result[31:16] and the final carry → DONE.
- **DONE**
  - `res_valid`=1; all `res_*` held stable.
  - On `res_valid`&`res_ready` → IDLE.
- **Carry for op 11**: the registered carry is forced to 0 and `alu_carryout` is ignored.
- In IDLE and DONE, `alu_a`, `alu_b`, `alu_opcode` and `alu_ci` are all driven 0.
- **Flags** (computed on the full width N = 16 or 32):
  - `res_zero` = result==0.
  - `res_neg` = result[N−1].
  - `res_carry` = final carry. For sub, 1 means no borrow.
  - `res_ovf`:
    - add: (a[N−1]==b[N−1]) & (r[N−1]!=a[N−1]).
    - sub: (a[N−1]!=b[N−1]) & (r[N−1]!=a[N−1]).
    - twos: b[N−1] & r[N−1].
    - xor: 0.
- One command in flight. No command overlap.

## Timing
- **Reset** (`rst` high at a rising edge):
  - Next state IDLE.
  - `res_valid`=0; `res_data`=0; all flags 0; `alu_*`=0.
  - `cmd_ready`=0 while `rst` is high, 1 in the first cycle after release.
- **Accept** at edge E0. LO occupies E0→E1.
  - Narrow: `res_valid` rises after E1.
  - Wide: HI occupies E1→E2; `res_valid` rises after E2.
- **Back-to-back**
  - Result accepted at edge Ek → IDLE; `cmd_ready`=1 after Ek.
  - Minimum period: 3 cycles narrow, 4 cycles wide.
- `cmd_ready`=0 in LO, HI and DONE. `cmd_valid` is ignored there.
- **Backpressure**: `res_ready` low holds DONE indefinitely with outputs unchanged.
- **Reset mid-operation** (LO, HI or DONE): the command is discarded and no result is emitted.
- **Wrap-around**: the carry-out of bit N−1 goes to `res_carry` only. The result wraps modulo 2^N.

## Test plan
1. **Narrow add, carry out.** op 00, narrow, a=0xFFFF, b=0x0001, ci=0 → `res_data`=0x0000_0000, carry=1, zero=1, neg=0, ovf=0. `res_valid` after E1.
2. **Wide add, carry chain.** op 00, wide, a=0x0000_FFFF, b=0x0000_0001 → 0x0001_0000, carry=0. `alu_ci`=1 during HI. `res_valid` after E2.
3. **Wide sub, borrow.**
   - a=0x0001_0000, b=0x0000_0001 → 0x0000_FFFF, carry=1.
   - a=0, b=1 → 0xFFFF_FFFF, carry=0, neg=1.
   - a=0x8000_0000, b=1 → 0x7FFF_FFFF, ovf=1.
4. **Wide two's complement.**
   - b=0 → 0, carry=1, zero=1.
   - b=0x8000_0000 → 0x8000_0000, neg=1, ovf=1.
   - b=1 → 0xFFFF_FFFF, carry=0.
5. **XOR carry masking.** Narrow xor, a=0xAAAA, b=0xAAAA, bench drives `alu_carryout`=1/X → `res_data`=0, zero=1, carry=0, ovf=0.
6. **Backpressure and reset.**
   - Hold `res_ready`=0 for 10 cycles → `res_*` stable, `cmd_ready`=0.
   - Assert `rst` in HI of a wide op → next cycle `res_valid`=0 and `alu_*`=0. `cmd_ready`=1 after release. No result is ever presented for that command.
